// File: rtl/islemci_ous_core_pkg.sv
// islemci_paket: constants and types shared by the multicycle core and its ALU.
// Holds opcode values, custom funct3 codes, stage encodings, the reset PC and
// an immediate decoder keyed on the opcode.
package islemci_paket;

  localparam logic [31:0] BASLANGIC_ADRES = 32'h8000_0000;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_DAL   = 7'b1100011;
  localparam logic [6:0] OP_YUKLE = 7'b0000011;
  localparam logic [6:0] OP_SAKLA = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OZEL     = 7'b1110011;

  localparam logic [2:0] KS = 3'd1;
  localparam logic [2:0] DS = 3'd2;

  typedef enum logic [1:0] {
    GETIR        = 2'd0,
    COZYAZMACOKU = 2'd1,
    YURUTGERIYAZ = 2'd2
  } asama_t;

  // Sign-extended immediate for every base format; I-type is the fallback.
  function automatic logic [31:0] anlik_coz(input logic [31:0] b);
    case (b[6:0])
      OP_SAKLA:         anlik_coz = {{20{b[31]}}, b[31:25], b[11:7]};
      OP_DAL:           anlik_coz = {{19{b[31]}}, b[31], b[7], b[30:25], b[11:8], 1'b0};
      OP_LUI, OP_AUIPC: anlik_coz = {b[31:12], 12'b0};
      OP_JAL:           anlik_coz = {{11{b[31]}}, b[31], b[19:12], b[20], b[30:21], 1'b0};
      default:          anlik_coz = {{20{b[31]}}, b[31:20]};
    endcase
  endfunction

endpackage

// File: rtl/islemci_ous_core_alu.sv
// islemci_alu: combinational RV32I integer ALU plus branch comparator.
// Ports: a, b operands; funct3 selects the operation (and branch condition);
// alt selects SUB/SRA; sonuc is the ALU result; dallan is the branch outcome.
module islemci_alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  funct3,
  input  logic        alt,
  output logic [31:0] sonuc,
  output logic        dallan
);

  always_comb begin
    sonuc = '0;
    case (funct3)
      3'b000: sonuc = alt ? (a - b) : (a + b);
      3'b001: sonuc = a << b[4:0];
      3'b010: sonuc = {31'b0, $signed(a) < $signed(b)};
      3'b011: sonuc = {31'b0, a < b};
      3'b100: sonuc = a ^ b;
      3'b101: sonuc = alt ? $unsigned($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'b110: sonuc = a | b;
      default: sonuc = a & b;
    endcase
  end

  // Branch funct3 010/011 are not defined, so they never branch.
  always_comb begin
    dallan = 1'b0;
    case (funct3)
      3'b000: dallan = (a == b);
      3'b001: dallan = (a != b);
      3'b100: dallan = ($signed(a) < $signed(b));
      3'b101: dallan = !($signed(a) < $signed(b));
      3'b110: dallan = (a < b);
      3'b111: dallan = (a >= b);
      default: dallan = 1'b0;
    endcase
  end

endmodule

// File: rtl/islemci_ous_core.sv
// islemci_ous_core: multicycle RV32I-subset core with ks (prefix-maxima
// compaction) and ds (block store) custom instructions.
// Ports: clk, rst (sync, active-high); bellek_adres / bellek_oku_veri form a
// combinational read port; bellek_yaz_veri + bellek_yaz write a word at
// bellek_adres on the rising edge.
module islemci_ous_core #(
  parameter logic [31:0] BASLANGIC_ADRES = islemci_paket::BASLANGIC_ADRES,
  parameter int          ADRES_BIT       = 32,
  parameter int          VERI_BIT        = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [ADRES_BIT-1:0] bellek_adres,
  input  logic [VERI_BIT-1:0]  bellek_oku_veri,
  output logic [VERI_BIT-1:0]  bellek_yaz_veri,
  output logic                 bellek_yaz
);
  import islemci_paket::*;

  localparam logic [ADRES_BIT-1:0] DORT = ADRES_BIT'(4);

  logic [ADRES_BIT-1:0] ps_r, ps_sonraki;
  asama_t               simdiki_asama_r, asama_next;
  logic                 ilerle_cmb;
  logic [VERI_BIT-1:0]  yazmac_obegi [0:31];

  logic [VERI_BIT-1:0]  buyruk_reg, rs1_deger_reg, rs2_deger_reg, anlik_reg;
  logic [4:0]           sayac_reg, sayac_next;          // custom-op element index
  logic [4:0]           ks_adet_reg, ks_adet_next;      // values kept so far
  logic [VERI_BIT-1:0]  ks_enbuyuk_reg, ks_enbuyuk_next;

  logic                 yaz_en;
  logic [4:0]           yaz_idx;
  logic [VERI_BIT-1:0]  yaz_veri;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd, rs1, rs2;
  assign opcode = buyruk_reg[6:0];
  assign rd     = buyruk_reg[11:7];
  assign funct3 = buyruk_reg[14:12];
  assign rs1    = buyruk_reg[19:15];
  assign rs2    = buyruk_reg[24:20];   // doubles as N for ks/ds
  assign funct7 = buyruk_reg[31:25];

  // Register read ports: two for decode, one live port for ks/ds sources.
  logic [4:0]          ozel_idx;
  logic [VERI_BIT-1:0] kaynak1, kaynak2, ozel_kaynak;
  assign ozel_idx    = rs1 + sayac_reg;
  assign kaynak1     = (rs1 == 5'd0) ? '0 : yazmac_obegi[rs1];
  // ds needs x[rd] as its base address, so custom ops read rd on port 2.
  assign kaynak2     = (opcode == OZEL) ? ((rd == 5'd0) ? '0 : yazmac_obegi[rd])
                                        : ((rs2 == 5'd0) ? '0 : yazmac_obegi[rs2]);
  assign ozel_kaynak = (ozel_idx == 5'd0) ? '0 : yazmac_obegi[ozel_idx];

  logic reg_gecerli, imm_gecerli, alu_alt;
  assign reg_gecerli = (funct7 == 7'b0) ||
                       (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
  assign imm_gecerli = (funct3 == 3'b001) ? (funct7 == 7'b0) :
                       (funct3 == 3'b101) ? (funct7 == 7'b0 || funct7 == 7'b0100000) : 1'b1;
  assign alu_alt     = (opcode == OP_REG) ? buyruk_reg[30]
                                          : (funct3 == 3'b101 && buyruk_reg[30]);

  logic [VERI_BIT-1:0] alu_b, alu_sonuc;
  logic                dallan;
  assign alu_b = (opcode == OP_REG || opcode == OP_DAL) ? rs2_deger_reg : anlik_reg;

  islemci_alu u_alu (
    .a      (rs1_deger_reg),
    .b      (alu_b),
    .funct3 (funct3),
    .alt    (alu_alt),
    .sonuc  (alu_sonuc),
    .dallan (dallan)
  );

  always_ff @(posedge clk) begin
    if (rst) simdiki_asama_r <= GETIR;
    else     simdiki_asama_r <= asama_next;
  end

  always_comb begin
    ilerle_cmb      = 1'b1;
    bellek_adres    = ps_r;
    bellek_yaz      = 1'b0;
    bellek_yaz_veri = '0;
    yaz_en          = 1'b0;
    yaz_idx         = rd;
    yaz_veri        = '0;
    ps_sonraki      = ps_r + DORT;
    sayac_next      = sayac_reg;
    ks_adet_next    = ks_adet_reg;
    ks_enbuyuk_next = ks_enbuyuk_reg;
    if (simdiki_asama_r == YURUTGERIYAZ) begin
      case (opcode)
        OP_LUI:   begin yaz_en = 1'b1; yaz_veri = anlik_reg; end
        OP_AUIPC: begin yaz_en = 1'b1; yaz_veri = ps_r + anlik_reg; end
        OP_JAL: begin
          yaz_en = 1'b1; yaz_veri = ps_r + DORT; ps_sonraki = ps_r + anlik_reg;
        end
        OP_JALR: if (funct3 == 3'b000) begin
          yaz_en = 1'b1; yaz_veri = ps_r + DORT;
          ps_sonraki = (rs1_deger_reg + anlik_reg) & ~ADRES_BIT'(1);
        end
        OP_DAL: if (dallan) ps_sonraki = ps_r + anlik_reg;
        OP_YUKLE: if (funct3 == 3'b010) begin
          bellek_adres = rs1_deger_reg + anlik_reg;
          yaz_en = 1'b1; yaz_veri = bellek_oku_veri;
        end
        OP_SAKLA: if (funct3 == 3'b010) begin
          bellek_adres = rs1_deger_reg + anlik_reg;
          bellek_yaz = 1'b1; bellek_yaz_veri = rs2_deger_reg;
        end
        OP_IMM: if (imm_gecerli) begin yaz_en = 1'b1; yaz_veri = alu_sonuc; end
        OP_REG: if (reg_gecerli) begin yaz_en = 1'b1; yaz_veri = alu_sonuc; end
        OZEL: if (funct3 == KS || funct3 == DS) begin
          ilerle_cmb = (sayac_reg == rs2);
          sayac_next = ilerle_cmb ? 5'd0 : sayac_reg + 5'd1;
          if (funct3 == KS) begin
            // First source is always kept; later ones only if strictly larger.
            if (ks_adet_reg == 5'd0 || ozel_kaynak > ks_enbuyuk_reg) begin
              yaz_en          = 1'b1;
              yaz_idx         = rd + ks_adet_reg;
              yaz_veri        = ozel_kaynak;
              ks_adet_next    = ks_adet_reg + 5'd1;
              ks_enbuyuk_next = ozel_kaynak;
            end
            if (ilerle_cmb) begin
              ks_adet_next    = 5'd0;
              ks_enbuyuk_next = '0;
            end
          end else begin
            bellek_adres    = rs2_deger_reg + VERI_BIT'({sayac_reg, 2'b00});
            bellek_yaz      = 1'b1;
            bellek_yaz_veri = ozel_kaynak;
          end
        end
        default: ;
      endcase
    end
    case (simdiki_asama_r)
      GETIR:        asama_next = COZYAZMACOKU;
      COZYAZMACOKU: asama_next = YURUTGERIYAZ;
      default:      asama_next = GETIR;
    endcase
    if (!ilerle_cmb) asama_next = simdiki_asama_r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ps_r           <= BASLANGIC_ADRES;
      buyruk_reg     <= '0;
      rs1_deger_reg  <= '0;
      rs2_deger_reg  <= '0;
      anlik_reg      <= '0;
      sayac_reg      <= '0;
      ks_adet_reg    <= '0;
      ks_enbuyuk_reg <= '0;
      for (int i = 0; i < 32; i++) yazmac_obegi[i] <= '0;
    end else begin
      case (simdiki_asama_r)
        GETIR: buyruk_reg <= bellek_oku_veri;
        COZYAZMACOKU: begin
          rs1_deger_reg <= kaynak1;
          rs2_deger_reg <= kaynak2;
          anlik_reg     <= anlik_coz(buyruk_reg);
        end
        YURUTGERIYAZ: begin
          sayac_reg      <= sayac_next;
          ks_adet_reg    <= ks_adet_next;
          ks_enbuyuk_reg <= ks_enbuyuk_next;
          if (ilerle_cmb) ps_r <= ps_sonraki;
          if (yaz_en && yaz_idx != 5'd0) yazmac_obegi[yaz_idx] <= yaz_veri;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_islemci_ous_core.sv
// Directed bench for islemci_ous_core with a word-addressed memory model.
module tb_islemci_ous_core;
  localparam logic [31:0] TABAN = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] bellek_adres, bellek_oku_veri, bellek_yaz_veri;
  logic        bellek_yaz;
  logic [31:0] mem [0:511];
  logic [8:0]  bellek_idx;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  islemci_ous_core dut (
    .clk             (clk),
    .rst             (rst),
    .bellek_adres    (bellek_adres),
    .bellek_oku_veri (bellek_oku_veri),
    .bellek_yaz_veri (bellek_yaz_veri),
    .bellek_yaz      (bellek_yaz)
  );

  assign bellek_idx      = 9'((bellek_adres - TABAN) >> 2);
  assign bellek_oku_veri = mem[bellek_idx];
  always @(posedge clk) if (bellek_yaz === 1'b1) mem[bellek_idx] = bellek_yaz_veri;

  function automatic logic [31:0] e_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] e_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] e_lui(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'b0110111};
  endfunction
  function automatic logic [31:0] e_sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] e_lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b010, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] e_beq(input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] e_jal(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction
  function automatic logic [31:0] e_ozel(input logic [2:0] f3, input logic [4:0] n,
                                         input logic [4:0] rs1, input logic [4:0] rd);
    return {7'd0, n, rs1, f3, rd, 7'b1110011};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    $display("vec %0d %s observed=%h expected=%h", vectors, tag, obs, exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Clears memory and places the eight addi x5..x12 instructions at 0x00..0x1C.
  task automatic onek_yukle();
    int ilk [8] = '{5, 10, 15, 12, 11, 25, 10, 21};
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    for (int i = 0; i < 8; i++) mem[i] = e_addi(5'(5 + i), 5'd0, 12'(ilk[i]));
  endtask

  // Steps until the core fetches at hedef, bounded by butce cycles.
  task automatic calistir(input logic [31:0] hedef, input int butce);
    int n = 0;
    while (!(dut.ps_r === hedef && dut.simdiki_asama_r === 2'd0) && n < butce) begin
      tick();
      n++;
    end
    chk("ps_reached", dut.ps_r, hedef);
  endtask

  function automatic logic [31:0] x(input int r);
    return dut.yazmac_obegi[r];
  endfunction

  initial begin
    int n;
    int w;
    int ilk [8] = '{5, 10, 15, 12, 11, 25, 10, 21};
    int ds_bek [6] = '{5, 10, 15, 12, 11, 25};

    // ---------------- Scenario A: base program, ks, sw/lw, branch, jal, ALU
    rst = 1'b1;
    tick();
    onek_yukle();
    mem[8]  = e_ozel(3'd1, 5'd7, 5'd5, 5'd16);     // ks x16, x5..x12
    mem[9]  = e_addi(5'd0, 5'd0, 12'd7);
    mem[10] = e_lui(5'd13, 20'h80000);
    mem[11] = e_addi(5'd13, 5'd13, 12'h100);
    mem[12] = e_sw(5'd6, 5'd13, 12'h040);
    mem[13] = e_lw(5'd20, 5'd13, 12'h040);
    mem[14] = e_beq(5'd6, 5'd11, 13'd8);
    mem[15] = e_addi(5'd21, 5'd0, 12'd99);
    mem[16] = e_jal(5'd1, 21'd8);
    mem[17] = e_addi(5'd22, 5'd0, 12'd77);
    mem[18] = e_addi(5'd23, 5'd0, 12'd1);
    mem[19] = e_r(7'b0000000, 5'd10, 5'd5, 3'b000, 5'd24);   // add
    mem[20] = e_r(7'b0100000, 5'd10, 5'd5, 3'b000, 5'd25);   // sub
    mem[21] = e_r(7'b0000000, 5'd10, 5'd5, 3'b011, 5'd26);   // sltu
    repeat (9) tick();

    chk("rst_ps", dut.ps_r, TABAN);
    chk("rst_stage", 32'(dut.simdiki_asama_r), 32'd0);
    chk("rst_yaz", 32'(bellek_yaz), 32'd0);
    chk("rst_yaz_veri", bellek_yaz_veri, 32'd0);
    chk("rst_x5", x(5), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      chk($sformatf("i%0d_getir", i), 32'(dut.simdiki_asama_r), 32'd0);
      chk($sformatf("i%0d_getir_ilerle", i), 32'(dut.ilerle_cmb), 32'd1);
      tick();
      chk($sformatf("i%0d_coz", i), 32'(dut.simdiki_asama_r), 32'd1);
      chk($sformatf("i%0d_coz_ilerle", i), 32'(dut.ilerle_cmb), 32'd1);
      tick();
      chk($sformatf("i%0d_yurut", i), 32'(dut.simdiki_asama_r), 32'd2);
      chk($sformatf("i%0d_yurut_ilerle", i), 32'(dut.ilerle_cmb), 32'd1);
      tick();
    end
    chk("addi_ps", dut.ps_r, TABAN + 32'h20);
    for (int i = 0; i < 8; i++) chk($sformatf("addi_x%0d", 5 + i), x(5 + i), 32'(ilk[i]));

    tick();
    tick();
    n = 0;
    while (dut.simdiki_asama_r === 2'd2 && n < 50) begin
      n++;
      tick();
    end
    chk("ks_cycles", 32'(n), 32'd8);
    chk("ks_x16", x(16), 32'd5);
    chk("ks_x17", x(17), 32'd10);
    chk("ks_x18", x(18), 32'd15);
    chk("ks_x19", x(19), 32'd25);
    chk("ks_x20", x(20), 32'd0);
    chk("ks_ps", dut.ps_r, TABAN + 32'h24);

    calistir(TABAN + 32'h30, 40);
    chk("x0_zero", x(0), 32'd0);
    chk("lui_addi_x13", x(13), 32'h8000_0100);

    calistir(TABAN + 32'h38, 40);
    chk("sw_mem", mem[80], 32'd10);
    chk("lw_x20", x(20), 32'd10);

    repeat (3) tick();
    chk("beq_target", dut.ps_r, TABAN + 32'h40);
    repeat (3) tick();
    chk("jal_target", dut.ps_r, TABAN + 32'h48);
    chk("jal_link", x(1), TABAN + 32'h44);
    chk("beq_skip_x21", x(21), 32'd0);

    calistir(TABAN + 32'h58, 60);
    chk("jal_skip_x22", x(22), 32'd0);
    chk("addi_x23", x(23), 32'd1);
    chk("add_x24", x(24), 32'd30);
    chk("sub_x25", x(25), 32'hFFFF_FFEC);
    chk("sltu_x26", x(26), 32'd1);

    // ---------------- Scenario B: ds block store
    rst = 1'b1;
    tick();
    onek_yukle();
    mem[8]  = e_lui(5'd13, 20'h80000);
    mem[9]  = e_addi(5'd13, 5'd13, 12'h030);
    mem[10] = e_ozel(3'd2, 5'd5, 5'd5, 5'd13);      // ds x5..x10 -> [x13]
    repeat (9) tick();
    rst = 1'b0;

    calistir(TABAN + 32'h28, 200);
    tick();
    tick();
    n = 0;
    w = 0;
    while (dut.simdiki_asama_r === 2'd2 && n < 50) begin
      n++;
      if (bellek_yaz === 1'b1) w++;
      tick();
    end
    chk("ds_cycles", 32'(n), 32'd6);
    chk("ds_writes", 32'(w), 32'd6);
    for (int i = 0; i < 6; i++) chk($sformatf("ds_mem%0d", i), mem[12 + i], 32'(ds_bek[i]));
    chk("ds_mem_past_end", mem[18], 32'd0);
    chk("ds_ps", dut.ps_r, TABAN + 32'h2C);
    chk("ds_yaz_after", 32'(bellek_yaz), 32'd0);

    // ---------------- Scenario C: reset during ds at i=2
    rst = 1'b1;
    tick();
    onek_yukle();
    mem[8]  = e_lui(5'd13, 20'h80000);
    mem[9]  = e_addi(5'd13, 5'd13, 12'h030);
    mem[10] = e_ozel(3'd2, 5'd5, 5'd5, 5'd13);
    repeat (9) tick();
    rst = 1'b0;

    calistir(TABAN + 32'h28, 200);
    repeat (4) tick();
    chk("abort_pre_yaz", 32'(bellek_yaz), 32'd1);
    chk("abort_pre_adres", bellek_adres, TABAN + 32'h38);
    rst = 1'b1;
    tick();
    chk("abort_stage", 32'(dut.simdiki_asama_r), 32'd0);
    chk("abort_ps", dut.ps_r, TABAN);
    chk("abort_yaz", 32'(bellek_yaz), 32'd0);
    chk("abort_x5", x(5), 32'd0);
    chk("abort_mem0", mem[12], 32'd5);
    chk("abort_mem1", mem[13], 32'd10);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
